// File: rtl/red_pitaya_pid_rail_mon.sv
// PID output rail supervisor: rail detect, debounce, center-reset, hold.
// Optional sticky rail flags enabled by defining RAIL_MON_STICKY_EN.
module red_pitaya_pid_rail_mon #(
  parameter int DW    = 14,
  parameter int CNT_W = 16,
  parameter int EVT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DW-1:0]    dat_i,
  input  logic             enable_i,
  input  logic [DW-1:0]    set_lo_i,
  input  logic [DW-1:0]    set_hi_i,
  input  logic [CNT_W-1:0] set_dbc_i,
  input  logic [CNT_W-1:0] set_hold_i,
  input  logic             cnt_clr_i,
  output logic [1:0]       railed_o,
  output logic             hold_o,
  output logic             int_ctr_rst_o,
  output logic [1:0]       state_o,
  output logic [EVT_W-1:0] rail_cnt_o,
  output logic [1:0]       sticky_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK   = 2'd1,
    RAILED  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] dcnt_inc;
  logic [CNT_W-1:0] hcnt_inc;
  logic [CNT_W-1:0] dbc_eff;
  logic [CNT_W-1:0] hold_eff;
  logic             rail_hit;

  // Zero settings behave as one cycle.
  assign dbc_eff  = (set_dbc_i == '0) ? CNT_W'(1) : set_dbc_i;
  assign hold_eff = (set_hold_i == '0) ? CNT_W'(1) : set_hold_i;
  assign dcnt_inc = dcnt + CNT_W'(1);
  assign hcnt_inc = hcnt + CNT_W'(1);

  // >= rather than == so a lowered debounce setting still trips.
  assign rail_hit = enable_i && (state == TRACK) &&
                    (railed_o != 2'b00) && (dcnt_inc >= dbc_eff);

  // Registered signed rail compare, active in every state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      railed_o <= 2'b00;
    end else begin
      railed_o[0] <= ($signed(dat_i) <= $signed(set_lo_i));
      railed_o[1] <= ($signed(dat_i) >= $signed(set_hi_i));
    end
  end

  // Supervisor FSM with debounce and hold counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      dcnt  <= '0;
      hcnt  <= '0;
    end else if (!enable_i) begin
      state <= IDLE;
      dcnt  <= '0;
      hcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= TRACK;
          dcnt  <= '0;
          hcnt  <= '0;
        end
        TRACK: begin
          hcnt <= '0;
          if (rail_hit) begin
            state <= RAILED;
            dcnt  <= '0;
          end else if (railed_o != 2'b00) begin
            dcnt <= dcnt_inc;
          end else begin
            dcnt <= '0;
          end
        end
        RAILED: begin
          state <= RECOVER;
          dcnt  <= '0;
          hcnt  <= '0;
        end
        RECOVER: begin
          dcnt <= '0;
          if (hcnt_inc >= hold_eff) begin
            state <= TRACK;
            hcnt  <= '0;
          end else begin
            hcnt <= hcnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          dcnt  <= '0;
          hcnt  <= '0;
        end
      endcase
    end
  end

  // Saturating rail-event counter; clear beats increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rail_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      rail_cnt_o <= '0;
    end else if (rail_hit && (rail_cnt_o != '1)) begin
      rail_cnt_o <= rail_cnt_o + EVT_W'(1);
    end
  end

`ifdef RAIL_MON_STICKY_EN
  // Sticky rail flags; a new rail wins over a clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sticky_o <= 2'b00;
    end else begin
      sticky_o <= (cnt_clr_i ? 2'b00 : sticky_o) | railed_o;
    end
  end
`else
  assign sticky_o = 2'b00;
`endif

  assign state_o       = state;
  assign int_ctr_rst_o = (state == RAILED);
  assign hold_o        = (state == RECOVER);

endmodule

// File: tb/tb_red_pitaya_pid_rail_mon.sv
// Bench for red_pitaya_pid_rail_mon.
// Directed scenarios plus random stimulus against a reference model.
module tb_red_pitaya_pid_rail_mon;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] dat, lo, hi;
  logic        en, clr;
  logic [15:0] dbc, hold;
  logic [1:0]  railed;
  logic        hold_o, ictr;
  logic [1:0]  state;
  logic [15:0] rail_cnt;
  logic [1:0]  sticky;

  int checks = 0;
  int errors = 0;

  int m_mode, m_streak, m_elapsed;
  int m_rail, m_cnt, m_sticky;

  always #5 clk = ~clk;

  red_pitaya_pid_rail_mon dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .dat_i        (dat),
    .enable_i     (en),
    .set_lo_i     (lo),
    .set_hi_i     (hi),
    .set_dbc_i    (dbc),
    .set_hold_i   (hold),
    .cnt_clr_i    (clr),
    .railed_o     (railed),
    .hold_o       (hold_o),
    .int_ctr_rst_o(ictr),
    .state_o      (state),
    .rail_cnt_o   (rail_cnt),
    .sticky_o     (sticky)
  );

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int sx(logic [13:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [13:0] to14(int v);
    int c;
    c = v;
    if (c > 8191) c = 8191;
    if (c < -8192) c = -8192;
    return c[13:0];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_streak = 0; m_elapsed = 0;
    m_rail = 0; m_cnt = 0; m_sticky = 0;
  endtask

  // One clock edge of the reference, using inputs seen at the edge.
  task automatic model_step();
    int r_new, dbc_e, hold_e;
    bit hit;
    r_new = ((sx(dat) >= sx(hi)) ? 2 : 0) |
            ((sx(dat) <= sx(lo)) ? 1 : 0);
    dbc_e  = (dbc == 0) ? 1 : int'(dbc);
    hold_e = (hold == 0) ? 1 : int'(hold);
    hit = 0;
    if (!en) begin
      m_mode = 0; m_streak = 0; m_elapsed = 0;
    end else begin
      case (m_mode)
        0: begin m_mode = 1; m_streak = 0; end
        1: begin
          if (m_rail != 0) begin
            m_streak++;
            if (m_streak >= dbc_e) begin
              hit = 1; m_mode = 2; m_streak = 0;
            end
          end else m_streak = 0;
        end
        2: begin m_mode = 3; m_elapsed = 0; end
        default: begin
          m_elapsed++;
          if (m_elapsed >= hold_e) begin
            m_mode = 1; m_elapsed = 0;
          end
        end
      endcase
    end
    if (clr) m_cnt = 0;
    else if (hit && m_cnt < 65535) m_cnt++;
`ifdef RAIL_MON_STICKY_EN
    m_sticky = (clr ? 0 : m_sticky) | m_rail;
`else
    m_sticky = 0;
`endif
    m_rail = r_new;
  endtask

  task automatic check_all();
    check("railed", 32'(railed), 32'(m_rail));
    check("hold", 32'(hold_o), 32'(m_mode == 3));
    check("ictr", 32'(ictr), 32'(m_mode == 2));
    check("state", 32'(state), 32'(m_mode));
    check("rail_cnt", 32'(rail_cnt), 32'(m_cnt));
    check("sticky", 32'(sticky), 32'(m_sticky));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    dat = '0; lo = '0; hi = '0;
    en = 1'b0; clr = 1'b0;
    dbc = '0; hold = '0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Persistent rail, then enable drop mid-recover, then re-arm.
    lo = to14(-8000); hi = to14(8000);
    dbc = 16'd4; hold = 16'd10;
    en = 1'b1; dat = to14(8100);
    for (int n = 1; n <= 30; n++) begin
      if (n == 25) en = 1'b0;
      if (n == 26) en = 1'b1;
      tick();
      if (n == 1)  check("t1_railed", 32'(railed), 32'd2);
      if (n == 4)  check("t1_no_pulse", 32'(ictr), 32'd0);
      if (n == 5)  check("t1_pulse", 32'(ictr), 32'd1);
      if (n == 6)  check("t1_hold_first", 32'(hold_o), 32'd1);
      if (n == 15) check("t1_hold_last", 32'(hold_o), 32'd1);
      if (n == 16) begin
        check("t1_track", 32'(state), 32'd1);
        check("t1_cnt", 32'(rail_cnt), 32'd1);
      end
      if (n == 25) begin
        check("t4_idle", 32'(state), 32'd0);
        check("t4_hold", 32'(hold_o), 32'd0);
        check("t4_cnt", 32'(rail_cnt), 32'd2);
      end
      if (n == 30) begin
        check("t4_rearm", 32'(ictr), 32'd1);
        check("t4_cnt3", 32'(rail_cnt), 32'd3);
      end
    end

    // Short rail burst does not trip.
    en = 1'b1; dat = 14'd0;
    repeat (12) tick();
    dat = to14(8100);
    repeat (3) tick();
    dat = 14'd0;
    repeat (6) tick();
    check("t2_cnt", 32'(rail_cnt), 32'd3);

    // Low rail seen while disabled.
    en = 1'b0; dat = to14(-8192);
    tick();
    check("t3_railed", 32'(railed), 32'd1);
    check("t3_idle", 32'(state), 32'd0);

    // Zero debounce/hold, clear coincident with RAILED entry.
    en = 1'b1; dbc = '0; hold = '0; dat = to14(8100);
    tick();
    clr = 1'b1;
    tick();
    check("t5_pulse", 32'(ictr), 32'd1);
    check("t5_clr", 32'(rail_cnt), 32'd0);
    clr = 1'b0;
    tick();
    check("t5_hold", 32'(hold_o), 32'd1);
    tick();
    check("t5_hold_end", 32'(hold_o), 32'd0);

    // Sticky flag behaviour.
    en = 1'b0; dat = '0; clr = 1'b1;
    repeat (2) tick();
    clr = 1'b0; dat = to14(8100);
    tick();
    dat = '0;
    repeat (3) tick();
`ifdef RAIL_MON_STICKY_EN
    check("t6_sticky", 32'(sticky), 32'd2);
`else
    check("t6_sticky", 32'(sticky), 32'd0);
`endif
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    check("t6_cleared", 32'(sticky), 32'd0);

    // Random operation.
    for (int i = 0; i < 4000; i++) begin
      en  = ($urandom % 60) != 0;
      clr = ($urandom % 50) == 0;
      if ($urandom % 150 == 0) begin
        lo = to14(-int'($urandom_range(8192, 200)));
        if ($urandom % 8 == 0)
          hi = to14(sx(lo) - int'($urandom_range(100, 0)));
        else
          hi = to14(int'($urandom_range(8191, 200)));
      end
      if ($urandom % 100 == 0) dbc = 16'($urandom_range(6, 0));
      if ($urandom % 60 == 0) hold = 16'($urandom_range(12, 0));
      case ($urandom % 4)
        0: dat = to14(sx(hi) - 40 + int'($urandom_range(200, 0)));
        1: dat = to14(sx(lo) + 40 - int'($urandom_range(200, 0)));
        2: dat = to14(sx(hi) + int'($urandom_range(50, 0)));
        default: dat = 14'($urandom);
      endcase
      tick();
      if (i % 997 == 500) begin
        #2 rst = 1'b1;
        #1;
        check("async_state", 32'(state), 32'd0);
        check("async_cnt", 32'(rail_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
